arith_unit_scheduler: RTL and testbench
=======================================

# arith_unit_scheduler

Request scheduler for the shared `sync_arith_unit_12` datapath. It accepts operation requests from two independent requesters over valid/ready handshakes and arbitrates between them round-robin. It drives the arithmetic unit's operand/opcode inputs, captures the registered result and status, and returns them to the granted requester. Only one operation is in flight at a time. It sits between the two command sources and the arithmetic unit.

## Interface
- `BITS`, 32, operand/result width; must match the arithmetic unit.
- `CNT_W`, 16, width of the saturating error counter.

- `i_clk`  in  1  single clock, rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  2  per-requester request valid.
- `o_req_ready`  out  2  per-requester accept; one-hot or zero.
- `i_req_A`  in  2*BITS  operand A; requester k uses slice [k*BITS +: BITS].
- `i_req_B`  in  2*BITS  operand B; same slicing.
- `i_req_op`  in  4  opcode; requester k uses slice [k*2 +: 2].
- `o_rsp_valid`  out  2  response valid; one-hot or zero.
- `i_rsp_ready`  in  2  per-requester response accept.
- `o_rsp_result`  out  BITS  captured result, shared by both requesters.
- `o_rsp_status`  out  4  captured status {ERROR, ODD_ZEROS, ZEROS, OVERFLOW}.
- `o_alu_A`, `o_alu_B`  out  BITS  operands to the arithmetic unit.
- `o_alu_op`  out  2  opcode to the arithmetic unit.
- `i_alu_result`  in  BITS  registered result from the arithmetic unit.
- `i_alu_status`  in  4  registered status from the arithmetic unit.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_err_count`  out  CNT_W  saturating count of completed operations whose status ERROR bit is 1.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on a handshake.
  - ISSUE → CAPTURE unconditionally.
  - CAPTURE → RESP unconditionally.
  - RESP → IDLE when `i_rsp_ready[gnt]` is 1.
- Arbitration in IDLE (combinational):
  - Grant k if only requester k is valid.
  - If both are valid, grant the requester other than `last_gnt`.
  - `o_req_ready[k]` = (state==IDLE) & grant[k]; both bits are 0 in every other state.
- On the handshake edge:
  - Latch A, B and op of the granted requester into operand registers.
  - Store `gnt`; set `last_gnt` = `gnt`.
- `o_alu_A`, `o_alu_B` and `o_alu_op` are driven directly from the operand registers. They hold the latched values continuously until the next accept.
- ISSUE: the arithmetic unit registers the operation at the end of this cycle.
- CAPTURE: on the closing edge, copy `i_alu_result` and `i_alu_status` into the response registers. If `i_alu_status[3]` is 1, increment `o_err_count`, saturating at all-ones.
- RESP:
  - `o_rsp_valid[gnt]` is 1.
  - `o_rsp_result` and `o_rsp_status` stay stable until `i_rsp_ready[gnt]` is 1.
  - `i_rsp_ready` of the non-granted requester is ignored.
- Opcode values are passed through unchecked; all four are legal.

## Timing
- Reset values: state IDLE, `last_gnt` = 1 (requester 0 wins the first tie), operand and response registers 0, `o_rsp_valid` = 00, `o_busy` = 0, `o_err_count` = 0.
- Handshake at edge N:
  - ISSUE during cycle N+1.
  - CAPTURE during cycle N+2.
  - `o_rsp_valid` rises in cycle N+3.
- Minimum accept-to-accept interval: 4 cycles (response ready in the first RESP cycle, then the next accept in IDLE).
- `o_req_ready` depends combinationally on `i_req_valid`. Requesters must not make valid depend on ready.
- Reset mid-operation, in any state:
  - Immediate return to reset values.
  - The in-flight operation is dropped and no response is issued.
  - The arithmetic unit shares `i_reset`.
- A request valid during RESP waits. It is arbitrated in the IDLE cycle that follows.

## Structure
- Package `arith_sched_pkg` holds:
  - `op_t` enum: OP_KONW=2'b00, OP_POROWN=2'b01, OP_USTAW=2'b10, OP_PRZES=2'b11.
  - `state_t` enum: IDLE, ISSUE, CAPTURE, RESP.
  - Status bit index constants: ST_ERROR=3, ST_ODD_ZEROS=2, ST_ZEROS=1, ST_OVERFLOW=0.
- One sub-module, `rr_arbiter_2`: combinational 2-way round-robin grant from `i_req_valid` and `last_gnt`.
- The arithmetic unit is instantiated outside this block.

## Test plan
The bench uses an arithmetic-unit stub with one-cycle registered latency. The stub returns result = A^B and status 4'b0000, or status 4'b1000 when A=32'hDEADBEEF.

- Reset release, no requests → `o_req_ready` = 00, `o_rsp_valid` = 00, `o_busy` = 0, `o_err_count` = 0.
- Requester 0: A=5, B=3, op=01 → accepted at edge N, `o_alu_op` = 01, `o_rsp_valid` = 01 in cycle N+3, result = 6, status = 0000.
- Both requesters valid continuously for 4 transactions → grant order 0, 1, 0, 1; each response goes to the matching `o_rsp_valid` bit.
- `i_rsp_ready` held 0 for 5 cycles in RESP → result and status stable, `o_req_ready` = 00, `o_busy` = 1; accepted on the 6th cycle.
- Three operations with A=32'hDEADBEEF → `o_rsp_status` = 1000 for each, `o_err_count` = 3.
- `i_reset` pulsed during CAPTURE → no response issued, all outputs at reset values; the next request completes normally with 4-cycle latency.

Source files
------------

// File: rtl/arith_sched_pkg.sv
// Shared types and constants for the arithmetic-unit request scheduler.
package arith_sched_pkg;

   typedef enum logic [1:0] {
      OP_KONW   = 2'b00,
      OP_POROWN = 2'b01,
      OP_USTAW  = 2'b10,
      OP_PRZES  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ISSUE   = 2'b01,
      CAPTURE = 2'b10,
      RESP    = 2'b11
   } state_t;

   localparam int ST_ERROR     = 3;
   localparam int ST_ODD_ZEROS = 2;
   localparam int ST_ZEROS     = 1;
   localparam int ST_OVERFLOW  = 0;

endpackage

// File: rtl/arith_unit_scheduler_rr_arbiter.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter_2 (
   input  logic [1:0] i_req_valid,
   input  logic       i_last_gnt,
   output logic [1:0] o_grant,
   output logic       o_gnt_idx
);

   // Grant selection from the current request vector and the previous winner.
   always_comb begin
      o_grant   = 2'b00;
      o_gnt_idx = 1'b0;
      case (i_req_valid)
         2'b01: begin
            o_grant   = 2'b01;
            o_gnt_idx = 1'b0;
         end
         2'b10: begin
            o_grant   = 2'b10;
            o_gnt_idx = 1'b1;
         end
         2'b11: begin
            if (i_last_gnt) begin
               o_grant   = 2'b01;
               o_gnt_idx = 1'b0;
            end else begin
               o_grant   = 2'b10;
               o_gnt_idx = 1'b1;
            end
         end
         default: begin
            o_grant   = 2'b00;
            o_gnt_idx = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/arith_unit_scheduler.sv
// Round-robin scheduler feeding one shared arithmetic unit; one operation in flight at a time.
module arith_unit_scheduler
   import arith_sched_pkg::*;
#(
   parameter int BITS  = 32,
   parameter int CNT_W = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [1:0]          i_req_valid,
   output logic [1:0]          o_req_ready,
   input  logic [2*BITS-1:0]   i_req_A,
   input  logic [2*BITS-1:0]   i_req_B,
   input  logic [3:0]          i_req_op,
   output logic [1:0]          o_rsp_valid,
   input  logic [1:0]          i_rsp_ready,
   output logic [BITS-1:0]     o_rsp_result,
   output logic [3:0]          o_rsp_status,
   output logic [BITS-1:0]     o_alu_A,
   output logic [BITS-1:0]     o_alu_B,
   output logic [1:0]          o_alu_op,
   input  logic [BITS-1:0]     i_alu_result,
   input  logic [3:0]          i_alu_status,
   output logic                o_busy,
   output logic [CNT_W-1:0]    o_err_count
);

   state_t           state_r, next_state_s;
   logic [1:0]       grant_s;
   logic             gnt_idx_s;
   logic             accept_s;
   logic             gnt_r, last_gnt_r;
   logic [BITS-1:0]  a_r, b_r, result_r;
   op_t              op_r;
   logic [3:0]       status_r;
   logic [1:0]       rsp_valid_r;
   logic             busy_r;
   logic [CNT_W-1:0] err_count_r;

   rr_arbiter_2 u_arb (
      .i_req_valid (i_req_valid),
      .i_last_gnt  (last_gnt_r),
      .o_grant     (grant_s),
      .o_gnt_idx   (gnt_idx_s)
   );

   // Ready is combinational on valid so an IDLE cycle can accept immediately.
   assign o_req_ready  = (state_r == IDLE) ? grant_s : 2'b00;
   assign accept_s     = (state_r == IDLE) && (grant_s != 2'b00);

   assign o_alu_A      = a_r;
   assign o_alu_B      = b_r;
   assign o_alu_op     = op_r;
   assign o_rsp_result = result_r;
   assign o_rsp_status = status_r;
   assign o_rsp_valid  = rsp_valid_r;
   assign o_busy       = busy_r;
   assign o_err_count  = err_count_r;

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               next_state_s = ISSUE;
            end else begin
               next_state_s = IDLE;
            end
         end
         ISSUE:   next_state_s = CAPTURE;
         CAPTURE: next_state_s = RESP;
         RESP: begin
            if (i_rsp_ready[gnt_r]) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RESP;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State register and registered busy flag.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s != IDLE);
      end
   end

   // Operand capture and grant bookkeeping on accept.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         a_r        <= {BITS{1'b0}};
         b_r        <= {BITS{1'b0}};
         op_r       <= OP_KONW;
         gnt_r      <= 1'b0;
         last_gnt_r <= 1'b1;
      end else if (accept_s) begin
         a_r        <= gnt_idx_s ? i_req_A[2*BITS-1:BITS] : i_req_A[BITS-1:0];
         b_r        <= gnt_idx_s ? i_req_B[2*BITS-1:BITS] : i_req_B[BITS-1:0];
         op_r       <= op_t'(gnt_idx_s ? i_req_op[3:2] : i_req_op[1:0]);
         gnt_r      <= gnt_idx_s;
         last_gnt_r <= gnt_idx_s;
      end
   end

   // Response capture, response valid and saturating error count.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         result_r    <= {BITS{1'b0}};
         status_r    <= 4'b0000;
         rsp_valid_r <= 2'b00;
         err_count_r <= {CNT_W{1'b0}};
      end else if (state_r == CAPTURE) begin
         result_r    <= i_alu_result;
         status_r    <= i_alu_status;
         rsp_valid_r <= gnt_r ? 2'b10 : 2'b01;
         if (i_alu_status[ST_ERROR] && (err_count_r != {CNT_W{1'b1}})) begin
            err_count_r <= err_count_r + CNT_W'(1);
         end
      end else if ((state_r == RESP) && i_rsp_ready[gnt_r]) begin
         rsp_valid_r <= 2'b00;
      end
   end

endmodule

// File: tb/tb_arith_unit_scheduler.sv
// Directed bench for arith_unit_scheduler with a one-cycle registered XOR arithmetic-unit stub.
module tb_arith_unit_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [63:0] req_a = 64'd0;
   logic [63:0] req_b = 64'd0;
   logic [3:0]  req_op = 4'd0;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready = 2'b00;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_status;
   logic [31:0] alu_a, alu_b;
   logic [1:0]  alu_op;
   logic [31:0] alu_result;
   logic [3:0]  alu_status;
   logic        busy;
   logic [15:0] err_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   arith_unit_scheduler #(.BITS(32), .CNT_W(16)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_A      (req_a),
      .i_req_B      (req_b),
      .i_req_op     (req_op),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_result (rsp_result),
      .o_rsp_status (rsp_status),
      .o_alu_A      (alu_a),
      .o_alu_B      (alu_b),
      .o_alu_op     (alu_op),
      .i_alu_result (alu_result),
      .i_alu_status (alu_status),
      .o_busy       (busy),
      .o_err_count  (err_count)
   );

   // Arithmetic-unit stub: registered A^B, ERROR status when A is DEADBEEF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_result <= 32'd0;
         alu_status <= 4'b0000;
      end else begin
         alu_result <= alu_a ^ alu_b;
         alu_status <= (alu_a == 32'hDEADBEEF) ? 4'b1000 : 4'b0000;
      end
   end

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] a0, b0, a1, b1;
      logic [1:0]  op0, op1;
      logic [1:0]  exp_gnt;
      logic [1:0]  exp_op;
      logic [31:0] exp_a;
      logic [31:0] exp_res;
      logic [3:0]  exp_st;
      logic [15:0] exp_err;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one request, check the accept and the pipeline up to the first RESP cycle (left at its negedge).
   task automatic issue_txn(input vec_t v);
      int waited;
      req_a     = {v.a1, v.a0};
      req_b     = {v.b1, v.b0};
      req_op    = {v.op1, v.op0};
      req_valid = v.valid;
      waited    = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("req_ready_grant", {30'd0, req_ready}, {30'd0, v.exp_gnt});
      @(posedge clk);
      #1;
      req_valid = (v.valid == 2'b11) ? 2'b11 : 2'b00;
      @(negedge clk);
      chk("issue_req_ready", {30'd0, req_ready}, 32'd0);
      chk("issue_busy", {31'd0, busy}, 32'd1);
      chk("alu_op", {30'd0, alu_op}, {30'd0, v.exp_op});
      chk("alu_a", alu_a, v.exp_a);
      @(negedge clk);
      chk("capture_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("resp_rsp_valid", {30'd0, rsp_valid}, {30'd0, v.exp_gnt});
      chk("resp_result", rsp_result, v.exp_res);
      chk("resp_status", {28'd0, rsp_status}, {28'd0, v.exp_st});
      chk("err_count", {16'd0, err_count}, {16'd0, v.exp_err});
   endtask

   // Accept the pending response for requester onehot g on the next edge.
   task automatic finish_rsp(input logic [1:0] g);
      rsp_ready = g;
      @(posedge clk);
      #1;
      rsp_ready = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      vec_t v;
      //          valid  a0            b0            a1            b1            op0   op1   gnt    op     exp_a         exp_res       st       err
      vecs[0] = '{2'b01, 32'd5,        32'd3,        32'd0,        32'd0,        2'b01,2'b00,2'b01, 2'b01, 32'd5,        32'd6,        4'b0000, 16'd0};
      vecs[1] = '{2'b10, 32'd0,        32'd0,        32'h0F0,      32'h00F,      2'b00,2'b10,2'b10, 2'b10, 32'h0F0,      32'h0FF,      4'b0000, 16'd0};
      vecs[2] = '{2'b11, 32'h1234,     32'h1200,     32'hFFFF0000, 32'h0000FFFF, 2'b00,2'b11,2'b01, 2'b00, 32'h1234,     32'h34,       4'b0000, 16'd0};
      vecs[3] = '{2'b11, 32'h1234,     32'h1200,     32'hFFFF0000, 32'h0000FFFF, 2'b00,2'b11,2'b10, 2'b11, 32'hFFFF0000, 32'hFFFFFFFF, 4'b0000, 16'd0};
      vecs[4] = '{2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'd1,        32'd1,        2'b01,2'b10,2'b01, 2'b01, 32'hA5A5A5A5, 32'hFFFFFFFF, 4'b0000, 16'd0};
      vecs[5] = '{2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'd1,        32'd1,        2'b01,2'b10,2'b10, 2'b10, 32'd1,        32'd0,        4'b0000, 16'd0};
      vecs[6] = '{2'b01, 32'hDEADBEEF, 32'd0,        32'd0,        32'd0,        2'b11,2'b00,2'b01, 2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1000, 16'd1};
      vecs[7] = '{2'b10, 32'd0,        32'd0,        32'hDEADBEEF, 32'hDEADBEEF, 2'b00,2'b00,2'b10, 2'b00, 32'hDEADBEEF, 32'd0,        4'b1000, 16'd2};
      vecs[8] = '{2'b11, 32'hDEADBEEF, 32'hFFFFFFFF, 32'd0,        32'd0,        2'b01,2'b00,2'b01, 2'b01, 32'hDEADBEEF, 32'h21524110, 4'b1000, 16'd3};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err_count", {16'd0, err_count}, 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         issue_txn(vecs[i]);
         finish_rsp(vecs[i].exp_gnt);
      end
      req_valid = 2'b00;

      // Response stall with only the non-granted ready asserted.
      v = '{2'b10, 32'd0, 32'd0, 32'h100, 32'h001, 2'b00, 2'b01, 2'b10, 2'b01, 32'h100, 32'h101, 4'b0000, 16'd3};
      issue_txn(v);
      req_a     = {32'd0, 32'h55};
      req_b     = {32'd0, 32'hAA};
      req_op    = 4'b0000;
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      for (int i = 0; i < 5; i++) begin
         chk("stall_rsp_valid", {30'd0, rsp_valid}, 32'h2);
         chk("stall_result", rsp_result, 32'h101);
         chk("stall_status", {28'd0, rsp_status}, 32'd0);
         chk("stall_req_ready", {30'd0, req_ready}, 32'd0);
         chk("stall_busy", {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      finish_rsp(2'b10);
      @(negedge clk);
      chk("post_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("waiting_req_ready", {30'd0, req_ready}, 32'd1);

      // Reset pulsed during CAPTURE drops the in-flight operation.
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("capture_busy", {31'd0, busy}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("rreset_busy", {31'd0, busy}, 32'd0);
      chk("rreset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("rreset_req_ready", {30'd0, req_ready}, 32'd0);
      chk("rreset_err_count", {16'd0, err_count}, 32'd0);
      chk("rreset_alu_a", alu_a, 32'd0);
      chk("rreset_alu_op", {30'd0, alu_op}, 32'd0);
      chk("rreset_result", rsp_result, 32'd0);
      chk("rreset_status", {28'd0, rsp_status}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("after_reset_no_rsp", {30'd0, rsp_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      v = '{2'b01, 32'd9, 32'hC, 32'd0, 32'd0, 2'b10, 2'b00, 2'b01, 2'b10, 32'd9, 32'd5, 4'b0000, 16'd0};
      issue_txn(v);
      finish_rsp(2'b01);
      @(negedge clk);
      chk("final_idle_busy", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
